// File: rtl/run_controller.sv
// Sequencer wrapping the single-cycle core: clear -> hold -> load PC -> run until halt or watchdog.
// Every output is registered from the next state, so a state's outputs show in its first cycle.
module run_controller #(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int CLR_CYCLES = 2,
  parameter int MAX_CYCLES = 4096,
  parameter logic [PC_W-1:0] PROG0_PC = '0,
  parameter logic [PC_W-1:0] PROG1_PC = '0,
  parameter logic [PC_W-1:0] PROG2_PC = '0,
  parameter logic [PC_W-1:0] PROG3_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             halt_in,
  output logic             core_rst,
  output logic             pc_load,
  output logic [PC_W-1:0]  start_pc,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HOLD,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CLR_W-1:0] clr_cnt;
  logic [CLR_W-1:0] clr_cnt_nxt;

  logic             core_rst_nxt;
  logic             pc_load_nxt;
  logic [PC_W-1:0]  start_pc_nxt;
  logic             core_en_nxt;
  logic [CNT_W-1:0] cycle_count_nxt;
  logic             done_nxt;
  logic             timeout_nxt;

  logic             wd_hit;
  logic             launch;
  logic [PC_W-1:0]  prog_pc;

  assign wd_hit = (cycle_count == WD_LAST);
  assign launch = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    prog_pc = PROG0_PC;
    case (prog_sel)
      2'd0:    prog_pc = PROG0_PC;
      2'd1:    prog_pc = PROG1_PC;
      2'd2:    prog_pc = PROG2_PC;
      default: prog_pc = PROG3_PC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      core_rst    <= 1'b1;
      pc_load     <= 1'b0;
      start_pc    <= '0;
      core_en     <= 1'b0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      core_rst    <= core_rst_nxt;
      pc_load     <= pc_load_nxt;
      start_pc    <= start_pc_nxt;
      core_en     <= core_en_nxt;
      cycle_count <= cycle_count_nxt;
      done        <= done_nxt;
      timeout     <= timeout_nxt;
    end
  end

  // In RUN an abort beats halt, and halt beats the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = S_HOLD;
      S_HOLD:  if (!start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN: begin
        if (start)                  state_nxt = S_CLEAR;
        else if (halt_in || wd_hit) state_nxt = S_DONE;
      end
      S_DONE:  if (start) state_nxt = S_CLEAR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clr_cnt_nxt = '0;
    if ((state == S_CLEAR) && (state_nxt == S_CLEAR)) clr_cnt_nxt = clr_cnt + 1'b1;

    core_rst_nxt = (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
    pc_load_nxt  = (state_nxt == S_LOAD);
    core_en_nxt  = (state_nxt == S_RUN);
    done_nxt     = (state_nxt == S_DONE);

    start_pc_nxt = start_pc;
    if (launch) start_pc_nxt = prog_pc;

    cycle_count_nxt = cycle_count;
    timeout_nxt     = timeout;
    if (state_nxt == S_CLEAR) begin
      cycle_count_nxt = '0;
      timeout_nxt     = 1'b0;
    end else if (state == S_RUN) begin
      // The cycle that ends the run is still counted.
      if (cycle_count != CNT_SAT) cycle_count_nxt = cycle_count + 1'b1;
      if (state_nxt == S_DONE) timeout_nxt = !halt_in;
    end
  end

  a_load_en_excl: assert property (@(posedge clk) disable iff (!reset) !(pc_load && core_en));
  a_rst_en_excl:  assert property (@(posedge clk) disable iff (!reset) !(core_rst && core_en));

endmodule
